// File: rtl/irq_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_req_latch
// Desc     : Pending-request latch and irq/ack handshake wrapped around an
//            external 8-to-3 priority encoder. Optional ack watchdog is
//            enabled by defining IRQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_req_latch #(
    parameter int N       = 8,
    parameter int IDXW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_in,
    input  logic [N-1:0]    mask,
    input  logic            edge_mode,
    output logic [N-1:0]    pend_out,
    output logic            enc_en_n,
    input  logic [IDXW-1:0] enc_idx,
    output logic            irq,
    output logic [IDXW-1:0] irq_idx,
    input  logic            ack,
    output logic            overflow,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_CLEAR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_req_q;
    logic [N-1:0]    r_pending;
    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_set;
    logic [N-1:0]    w_clr;
    logic [N-1:0]    w_pending_nxt;
    logic            r_irq;
    logic            w_irq_nxt;
    logic [IDXW-1:0] r_irq_idx;
    logic [IDXW-1:0] w_irq_idx_nxt;
    logic            r_overflow;
    logic            w_ack_take;
    logic            w_tmo_fire;
    logic            w_enc_hit;

    if (N != (1 << IDXW) || TIMEOUT < 1) begin : g_param_check
        $error("irq_req_latch: N must equal 2**IDXW and TIMEOUT must be >= 1");
    end

    assign w_rise     = req_in & ~r_req_q;
    assign w_ack_take = (r_state == S_ASSERT) && ack;

    // A set landing in the same cycle as the clear of the same bit wins.
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign w_set[gi]         = edge_mode ? w_rise[gi] : req_in[gi];
        assign w_clr[gi]         = w_ack_take && (r_irq_idx == IDXW'(gi));
        assign w_pending_nxt[gi] = w_set[gi] | (r_pending[gi] & ~w_clr[gi]);
    end

    assign pend_out = r_pending & ~mask;
    assign enc_en_n = (r_state != S_IDLE);

    // Only trust the encoder when its index points at a live bit.
    assign w_enc_hit = (|pend_out) && pend_out[enc_idx];

    always_comb begin
        w_state_nxt   = r_state;
        w_irq_nxt     = r_irq;
        w_irq_idx_nxt = r_irq_idx;
        case (r_state)
            S_IDLE: begin
                if (w_enc_hit) begin
                    w_state_nxt   = S_ASSERT;
                    w_irq_nxt     = 1'b1;
                    w_irq_idx_nxt = enc_idx;
                end
            end
            S_ASSERT: begin
                if (ack || w_tmo_fire) begin
                    w_state_nxt = S_CLEAR;
                    w_irq_nxt   = 1'b0;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_irq_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req_q    <= '0;
            r_pending  <= '0;
            r_irq      <= 1'b0;
            r_irq_idx  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_q    <= req_in;
            r_pending  <= w_pending_nxt;
            r_irq      <= w_irq_nxt;
            r_irq_idx  <= w_irq_idx_nxt;
            r_overflow <= r_overflow | (edge_mode & (|(w_rise & r_pending)));
        end
    end

    assign irq      = r_irq;
    assign irq_idx  = r_irq_idx;
    assign overflow = r_overflow;

`ifdef IRQ_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout;

    // Counter sits at zero outside ASSERT, so every entry starts a fresh window;
    // firing on the last count gives exactly TIMEOUT cycles of irq=1.
    assign w_tmo_fire = (r_state == S_ASSERT) && !ack && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_ASSERT) begin
                r_tmo_cnt <= '0;
            end else if (!w_tmo_fire) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_tmo_fire = 1'b0;
    assign timeout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_irq_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_req_latch
// Desc     : Directed vector table plus hand sequences for irq_req_latch,
//            with a behavioural highest-index-wins encoder in the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_req_latch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       edge_mode = 1'b1;
    logic [7:0] pend_out;
    logic       enc_en_n;
    logic [2:0] enc_idx;
    logic       irq;
    logic [2:0] irq_idx;
    logic       ack = 1'b0;
    logic       overflow;
    logic       timeout;

    logic       enc_force = 1'b0;
    logic [2:0] enc_force_val = 3'd0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] msk;
        logic       em;
        logic       ak;
        logic       e_irq;
        logic [2:0] e_idx;
        logic [7:0] e_pend;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[40];
    int   nv = 0;

    irq_req_latch #(.N(8), .IDXW(3), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .edge_mode(edge_mode),
        .pend_out (pend_out),
        .enc_en_n (enc_en_n),
        .enc_idx  (enc_idx),
        .irq      (irq),
        .irq_idx  (irq_idx),
        .ack      (ack),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Reference 8-to-3 encoder: highest set index wins.
    always_comb begin
        enc_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_out[i]) enc_idx = 3'(i);
        end
        if (enc_force) enc_idx = enc_force_val;
    end

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic e, input logic a);
        req_in    = r;
        mask      = m;
        edge_mode = e;
        ack       = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic [7:0] r, input logic [7:0] m, input logic e, input logic a,
                     input logic ei, input logic [2:0] ex, input logic [7:0] ep, input logic eo);
        vecs[nv] = '{r, m, e, a, ei, ex, ep, eo};
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hi;

        //  req    mask   em    ack   irq   idx   pend   ovf
        v(8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0); // ack in IDLE ignored
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h84, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h84, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 8'h84, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h04, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h04, 1'b0); // CLEAR cycle
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0); // masked line
        v(8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        v(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        v(8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h08, 1'b1); // overflow, set wins
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 1'b1);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1);
        v(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        v(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        v(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 1'b1); // level mode
        v(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1);
        v(8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10, 1'b1);
        v(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 1'b1);
        v(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1);
        v(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1);
        v(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        v(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

        rst = 1'b1;
        step(8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_idx", irq_idx, 3'd0);
        chk("rst_pend", pend_out, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_tmo", timeout, 1'b0);
        chk("rst_en_n", enc_en_n, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            step(vecs[i].req, vecs[i].msk, vecs[i].em, vecs[i].ak);
            chk($sformatf("v%0d_irq", i), irq, vecs[i].e_irq);
            if (vecs[i].e_irq) chk($sformatf("v%0d_idx", i), irq_idx, vecs[i].e_idx);
            chk($sformatf("v%0d_pend", i), pend_out, vecs[i].e_pend);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
        end

        // Ack watchdog (or its absence) on line 6.
        step(8'h40, 8'h00, 1'b1, 1'b0);
        chk("tmo_pend", pend_out, 8'h40);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("tmo_raise", {irq, irq_idx}, {1'b1, 3'd6});
        chk("tmo_en_n", enc_en_n, 1'b1);
        hi = 1;
        for (int k = 0; k < 40 && irq; k++) begin
            step(8'h00, 8'h00, 1'b1, 1'b0);
            if (irq) hi++;
        end
`ifdef IRQ_TIMEOUT_EN
        chk("tmo_len", hi, 16);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_keep", pend_out, 8'h40);
        chk("tmo_clear_en_n", enc_en_n, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("tmo_gap", irq, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("tmo_retry", {irq, irq_idx}, {1'b1, 3'd6});
`else
        chk("notmo_len", hi, 41);
        chk("notmo_flag", timeout, 1'b0);
`endif
        step(8'h00, 8'h00, 1'b1, 1'b1);
        chk("tmo_ack_irq", irq, 1'b0);
        chk("tmo_ack_pend", pend_out, 8'h00);
        step(8'h00, 8'h00, 1'b1, 1'b0);

        // No preemption in ASSERT, then reset mid-interrupt.
        step(8'h20, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("np_raise", {irq, irq_idx}, {1'b1, 3'd5});
        step(8'h80, 8'h00, 1'b1, 1'b0);
        chk("np_hold", {irq, irq_idx}, {1'b1, 3'd5});
        chk("np_pend", pend_out, 8'ha0);
        step(8'h00, 8'h20, 1'b1, 1'b0);
        chk("np_mask", {irq, irq_idx}, {1'b1, 3'd5});
        chk("np_mask_pend", pend_out, 8'h80);
        rst = 1'b1;
        step(8'h00, 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        chk("mrst_irq", irq, 1'b0);
        chk("mrst_pend", pend_out, 8'h00);
        chk("mrst_ovf", overflow, 1'b0);
        chk("mrst_tmo", timeout, 1'b0);
        chk("mrst_en_n", enc_en_n, 1'b0);

        // Encoder pointing at an empty bit must be ignored.
        step(8'h02, 8'h00, 1'b1, 1'b0);
        chk("bad_pend", pend_out, 8'h02);
        enc_force     = 1'b1;
        enc_force_val = 3'd5;
        for (int k = 0; k < 3; k++) begin
            step(8'h00, 8'h00, 1'b1, 1'b0);
            chk($sformatf("bad_idle%0d", k), {irq, enc_en_n}, 2'b00);
        end
        enc_force = 1'b0;
        step(8'h00, 8'h00, 1'b1, 1'b0);
        chk("bad_recover", {irq, irq_idx}, {1'b1, 3'd1});
        step(8'h00, 8'h00, 1'b1, 1'b1);
        chk("bad_ack", {irq, pend_out}, {1'b0, 8'h00});
        step(8'h00, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
